// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline constants: register-file geometry and the operand-select encoding.
package rv32_pkg;

  localparam int unsigned NUM_WIDTH = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned SEL_RF    = 0;

  // Completion-bus select code sits just past the last forwarding stage.
  function automatic int unsigned SEL_LO(input int unsigned fwd_stages);
    return fwd_stages + 1;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority search for one EX source: nearest writing stage, then the long-latency completion bus.
module fwd_select #(
  parameter int unsigned NUM_WIDTH  = rv32_pkg::NUM_WIDTH,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [NUM_WIDTH-1:0]            src,
  input  logic [FWD_STAGES*NUM_WIDTH-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]           fwd_regwr,
  input  logic [FWD_STAGES-1:0]           fwd_ready,
  input  logic                            lo_done,
  input  logic [NUM_WIDTH-1:0]            lo_done_rd,
  output logic [SEL_W-1:0]                sel,
  output logic                            hit,
  output logic                            hit_ready
);
  import rv32_pkg::*;

  always_comb begin
    sel       = SEL_W'(SEL_RF);
    hit       = 1'b0;
    hit_ready = 1'b1;
    if (src != '0) begin
      // Stage 0 is scanned first, so the first match found is the youngest producer.
      for (int unsigned k = 0; k < FWD_STAGES; k++) begin
        if (!hit && fwd_regwr[k] && (fwd_rd[k*NUM_WIDTH +: NUM_WIDTH] == src)) begin
          hit       = 1'b1;
          hit_ready = fwd_ready[k];
          sel       = SEL_W'(k + 1);
        end
      end
      if (!hit && lo_done && (lo_done_rd == src)) begin
        hit = 1'b1;
        sel = SEL_W'(SEL_LO(FWD_STAGES));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass selection, load-use / long-latency stall generation and busy scoreboard for EX.
module fwd_hazard_unit #(
  parameter int unsigned  NUM_WIDTH  = rv32_pkg::NUM_WIDTH,
  parameter int unsigned  NUM_REGS   = rv32_pkg::NUM_REGS,
  parameter int unsigned  FWD_STAGES = 2,
  parameter int unsigned  CNT_W      = 16,
  localparam int unsigned SEL_W      = $clog2(FWD_STAGES + 2)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_valid,
  input  logic [NUM_WIDTH-1:0]            ex_rs1,
  input  logic [NUM_WIDTH-1:0]            ex_rs2,
  input  logic [NUM_WIDTH-1:0]            ex_rd,
  input  logic                            ex_regwr,
  input  logic [FWD_STAGES*NUM_WIDTH-1:0] fwd_rd,
  input  logic [FWD_STAGES-1:0]           fwd_regwr,
  input  logic [FWD_STAGES-1:0]           fwd_ready,
  input  logic                            lo_issue,
  input  logic [NUM_WIDTH-1:0]            lo_rd,
  input  logic                            lo_done,
  input  logic [NUM_WIDTH-1:0]            lo_done_rd,
  output logic [SEL_W-1:0]                ex_rs1src,
  output logic [SEL_W-1:0]                ex_rs2src,
  output logic                            stall,
  output logic [NUM_REGS-1:0]             busy_vec,
  output logic [CNT_W-1:0]                stall_cnt
);
  import rv32_pkg::*;

  logic [SEL_W-1:0]    sel1, sel2;
  logic                hit1, hit2, hit1_ready, hit2_ready;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                active, load_use, busy_block, waw;

  fwd_select #(.NUM_WIDTH(NUM_WIDTH), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_sel_rs1 (
    .src(ex_rs1), .fwd_rd(fwd_rd), .fwd_regwr(fwd_regwr), .fwd_ready(fwd_ready),
    .lo_done(lo_done), .lo_done_rd(lo_done_rd),
    .sel(sel1), .hit(hit1), .hit_ready(hit1_ready)
  );

  fwd_select #(.NUM_WIDTH(NUM_WIDTH), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_sel_rs2 (
    .src(ex_rs2), .fwd_rd(fwd_rd), .fwd_regwr(fwd_regwr), .fwd_ready(fwd_ready),
    .lo_done(lo_done), .lo_done_rd(lo_done_rd),
    .sel(sel2), .hit(hit2), .hit_ready(hit2_ready)
  );

  always_comb begin
    active     = ex_valid && !rst;
    load_use   = (hit1 && !hit1_ready) || (hit2 && !hit2_ready);
    // x0 never gets a busy bit, so an unused source encoded as x0 cannot block.
    busy_block = (busy_q[ex_rs1] && !hit1) || (busy_q[ex_rs2] && !hit2);
    waw        = ex_regwr && busy_q[ex_rd] && !(lo_done && (lo_done_rd == ex_rd));
    stall      = active && (load_use || busy_block || waw);
    ex_rs1src  = active ? sel1 : '0;
    ex_rs2src  = active ? sel2 : '0;
  end

  // Clear before set so a same-edge issue to a completing register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (lo_done)
      busy_d[lo_done_rd] = 1'b0;
    if (lo_issue && !stall)
      busy_d[lo_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy_vec  = busy_q;
  assign stall_cnt = cnt_q;

  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst) !(lo_issue && stall));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a rule-level reference model checked every cycle.
module tb_fwd_hazard_unit;

  localparam int unsigned NW = 5;
  localparam int unsigned NR = 32;
  localparam int unsigned FS = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = $clog2(FS + 2);
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic             clk, rst;
  logic             ex_valid, ex_regwr;
  logic [NW-1:0]    ex_rs1, ex_rs2, ex_rd;
  logic [FS*NW-1:0] fwd_rd;
  logic [FS-1:0]    fwd_regwr, fwd_ready;
  logic             lo_issue, lo_done;
  logic [NW-1:0]    lo_rd, lo_done_rd;
  logic [SW-1:0]    ex_rs1src, ex_rs2src;
  logic             stall;
  logic [NR-1:0]    busy_vec;
  logic [CW-1:0]    stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit [NR-1:0] m_busy = '0;
  int unsigned m_cnt  = 0;

  fwd_hazard_unit #(.NUM_WIDTH(NW), .NUM_REGS(NR), .FWD_STAGES(FS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .fwd_rd(fwd_rd), .fwd_regwr(fwd_regwr),
    .fwd_ready(fwd_ready), .lo_issue(lo_issue), .lo_rd(lo_rd), .lo_done(lo_done),
    .lo_done_rd(lo_done_rd), .ex_rs1src(ex_rs1src), .ex_rs2src(ex_rs2src),
    .stall(stall), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: youngest writing stage, else completion bus, else register file.
  function automatic int raw_sel(input logic [NW-1:0] s);
    if (s == 0) return 0;
    for (int k = 0; k < FS; k++)
      if (fwd_regwr[k] && fwd_rd[k*NW +: NW] == s) return k + 1;
    if (lo_done && lo_done_rd == s) return FS + 1;
    return 0;
  endfunction

  function automatic int exp_sel(input logic [NW-1:0] s);
    if (rst || !ex_valid) return 0;
    return raw_sel(s);
  endfunction

  function automatic bit exp_stall();
    logic [NW-1:0] srcs [2];
    if (rst || !ex_valid) return 1'b0;
    srcs[0] = ex_rs1;
    srcs[1] = ex_rs2;
    foreach (srcs[i]) begin
      int sel = raw_sel(srcs[i]);
      if (sel >= 1 && sel <= FS && !fwd_ready[sel-1]) return 1'b1;
      if (m_busy[srcs[i]] && sel == 0) return 1'b1;
    end
    if (ex_regwr && m_busy[ex_rd] && !(lo_done && lo_done_rd == ex_rd)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0;
      m_cnt  <= 0;
    end else begin
      automatic bit st = exp_stall();
      if (st && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (lo_done) m_busy[lo_done_rd] <= 1'b0;
      if (lo_issue && !st && lo_rd != 0) m_busy[lo_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("rs1src",    64'(ex_rs1src), 64'(exp_sel(ex_rs1)));
    check("rs2src",    64'(ex_rs2src), 64'(exp_sel(ex_rs2)));
    check("stall",     64'(stall),     64'(exp_stall()));
    check("busy_vec",  64'(busy_vec),  64'(m_busy));
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic [NW-1:0] rd, input logic wr, input logic rdy);
    fwd_rd[k*NW +: NW] = rd;
    fwd_regwr[k]       = wr;
    fwd_ready[k]       = rdy;
  endtask

  task automatic clear_in();
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwr = 0;
    fwd_rd = '0; fwd_regwr = '0; fwd_ready = '0;
    lo_issue = 0; lo_rd = 0; lo_done = 0; lo_done_rd = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    // Outputs must stay quiet under reset even with a live forwarding match.
    ex_valid = 1; ex_rs1 = 5;
    set_fwd(0, 5, 1, 0);
    step(); step();
    #2;
    check("rst_rs1src", 64'(ex_rs1src), 64'd0);
    check("rst_stall",  64'(stall),     64'd0);
    check("rst_busy",   64'(busy_vec),  64'd0);
    check("rst_cnt",    64'(stall_cnt), 64'd0);
    step();
    rst = 1'b0;
    clear_in();
    step();

    // Nearest stage wins.
    ex_valid = 1; ex_rs1 = 5;
    set_fwd(0, 5, 1, 1);
    set_fwd(1, 5, 1, 1);
    #2;
    check("t1_rs1src", 64'(ex_rs1src), 64'd1);
    check("t1_stall",  64'(stall),     64'd0);
    step();
    // Non-writing match does not shadow a deeper stage.
    set_fwd(0, 5, 0, 1);
    #2;
    check("t2_rs1src", 64'(ex_rs1src), 64'd2);
    step();
    ex_rs1 = 0;
    set_fwd(0, 0, 1, 1);
    #2;
    check("t2_x0", 64'(ex_rs1src), 64'd0);
    step();

    // Load-use: stall while the load sits in MEM, forward from WB next cycle.
    clear_in();
    ex_valid = 1; ex_rs2 = 7;
    set_fwd(0, 7, 1, 0);
    #2;
    check("t3_stall", 64'(stall), 64'd1);
    step();
    set_fwd(0, 0, 0, 0);
    set_fwd(1, 7, 1, 1);
    #2;
    check("t3_rs2src", 64'(ex_rs2src), 64'd2);
    check("t3_stall2", 64'(stall),     64'd0);
    step();

    // Long-latency dependence on x9.
    clear_in();
    lo_issue = 1; lo_rd = 9;
    step();
    lo_issue = 0;
    #2;
    check("t4_busy_set", 64'(busy_vec[9]), 64'd1);
    step(); step();
    ex_valid = 1; ex_rs1 = 9;
    #2;
    check("t4_stall", 64'(stall), 64'd1);
    step();
    #2;
    check("t4_stall_held", 64'(stall),       64'd1);
    check("t4_busy_held",  64'(busy_vec[9]), 64'd1);
    step();
    lo_done = 1; lo_done_rd = 9;
    #2;
    check("t4_rs1src_lo", 64'(ex_rs1src), 64'(FS + 1));
    check("t4_stall_lo",  64'(stall),     64'd0);
    step();
    clear_in();
    #2;
    check("t4_busy_clr", 64'(busy_vec[9]), 64'd0);
    step();

    // Same-edge done and issue to x4: set wins, then WAW guard.
    lo_issue = 1; lo_rd = 4;
    step();
    lo_done = 1; lo_done_rd = 4;
    step();
    clear_in();
    ex_valid = 1; ex_rd = 4; ex_regwr = 1;
    #2;
    check("t5_busy4", 64'(busy_vec[4]), 64'd1);
    check("t5_waw",   64'(stall),       64'd1);
    step();
    lo_done = 1; lo_done_rd = 4;
    #2;
    check("t5_waw_done", 64'(stall), 64'd0);
    step();
    clear_in();
    #2;
    check("t5_busy4_clr", 64'(busy_vec[4]), 64'd0);

    // x0 is never marked busy.
    lo_issue = 1; lo_rd = 0;
    step();
    clear_in();
    #2;
    check("x0_busy", 64'(busy_vec), 64'd0);

    // Busy source satisfied by a ready stage forward.
    lo_issue = 1; lo_rd = 12;
    step();
    lo_issue = 0;
    ex_valid = 1; ex_rs2 = 12;
    set_fwd(1, 12, 1, 1);
    #2;
    check("busy_fwd_sel",   64'(ex_rs2src), 64'd2);
    check("busy_fwd_stall", 64'(stall),     64'd0);
    step();
    set_fwd(1, 0, 0, 0);
    #2;
    check("busy_nofwd_stall", 64'(stall), 64'd1);
    step();
    clear_in();
    lo_done = 1; lo_done_rd = 12;
    step();
    clear_in();

    // Counter saturation, then async reset mid-stall.
    lo_issue = 1; lo_rd = 20;
    step();
    clear_in();
    ex_valid = 1; ex_rs1 = 7;
    set_fwd(0, 7, 1, 0);
    for (int i = 0; i < (1 << CW) + 3; i++) step();
    #2;
    check("t6_cnt_sat", 64'(stall_cnt),    64'(CNT_MAX));
    check("t6_busy20",  64'(busy_vec[20]), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy",  64'(busy_vec),  64'd0);
    check("t6_rst_cnt",   64'(stall_cnt), 64'd0);
    check("t6_rst_stall", 64'(stall),     64'd0);
    step(); step();
    rst = 1'b0;
    clear_in();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
